// File: rtl/multi_rate_tick_gen_pkg.sv
// Shared constants and helpers for the multi-rate tick generator.
package multi_rate_tick_gen_pkg;

  localparam int unsigned DefSelW      = 3;
  localparam int unsigned DefBaseShift = 21;

  // Counter width wide enough to hold P-1 for the largest select value.
  function automatic int unsigned cnt_width(input int unsigned sel_w,
                                            input int unsigned base_shift);
    return sel_w + 1 + base_shift;
  endfunction

  // Period in clocks: the odd multiplier (2*sel+1) scaled by 2^base_shift.
  function automatic logic [63:0] period(input logic [31:0] sel,
                                         input int unsigned base_shift);
    return ((64'(sel) << 1) | 64'd1) << base_shift;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One divided-rate channel: period counter, latched rate select, square wave and tick.
module tick_channel
  import multi_rate_tick_gen_pkg::*;
#(
  parameter int unsigned SEL_W      = DefSelW,
  parameter int unsigned BASE_SHIFT = DefBaseShift
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic [SEL_W-1:0] sel,
  output logic             sq_out,
  output logic             tick
);

  localparam int unsigned CNT_W = cnt_width(SEL_W, BASE_SHIFT);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
  logic [CNT_W-1:0] period_len, half_len;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             sq_q, sq_d;
  logic             tick_q, tick_d;
  logic             wrap;

  // Period follows the latched select only, so mid-period sel changes cannot shorten it.
  assign period_len = CNT_W'(period(32'(sel_q), BASE_SHIFT));
  assign half_len   = period_len >> 1;
  assign wrap       = (cnt_q == (period_len - CNT_W'(1)));
  assign cnt_next   = wrap ? '0 : (cnt_q + CNT_W'(1));

  // Next-state: restart beats enable; disabled channels hold everything but tick.
  always_comb begin
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    sq_d   = sq_q;
    tick_d = 1'b0;
    if (restart) begin
      cnt_d = '0;
      sel_d = sel;
      sq_d  = 1'b1;
    end else if (en) begin
      cnt_d  = cnt_next;
      sq_d   = (cnt_next < half_len);
      tick_d = wrap;
      if (wrap) begin
        sel_d = sel;
      end
    end
  end

  // State register with synchronous reset; sel is sampled during reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sel_q  <= sel;
      sq_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      sq_q   <= sq_d;
      tick_q <= tick_d;
    end
  end

  assign sq_out = sq_q;
  assign tick   = tick_q;

endmodule

// File: rtl/multi_rate_tick_gen.sv
// NUM_CH independent divided-rate square-wave and tick generators.
module multi_rate_tick_gen
  import multi_rate_tick_gen_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned SEL_W      = DefSelW,
  parameter int unsigned BASE_SHIFT = DefBaseShift
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       restart,
  input  logic [NUM_CH*SEL_W-1:0] sel,
  output logic [NUM_CH-1:0]       sq_out,
  output logic [NUM_CH-1:0]       tick
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_channel #(
      .SEL_W      (SEL_W),
      .BASE_SHIFT (BASE_SHIFT)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .en      (en[i]),
      .restart (restart[i]),
      .sel     (sel[i*SEL_W +: SEL_W]),
      .sq_out  (sq_out[i]),
      .tick    (tick[i])
    );
  end

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// Directed and randomized checks of multi_rate_tick_gen against a period-position model.
module tb_multi_rate_tick_gen;

  localparam int unsigned NCh = 2;
  localparam int unsigned SW  = 2;
  localparam int unsigned BS  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCh-1:0]    en;
  logic [NCh-1:0]    restart;
  logic [NCh*SW-1:0] sel;
  logic [NCh-1:0]    sq_out;
  logic [NCh-1:0]    tick;

  int n_chk = 0;
  int n_err = 0;

  // Reference: position within the current period plus the rate in force.
  int m_pos [NCh];
  int m_rate[NCh];
  bit m_sq  [NCh];
  bit m_tk  [NCh];

  always #5 clk = ~clk;

  multi_rate_tick_gen #(
    .NUM_CH     (NCh),
    .SEL_W      (SW),
    .BASE_SHIFT (BS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .restart (restart),
    .sel     (sel),
    .sq_out  (sq_out),
    .tick    (tick)
  );

  function automatic int sel_of(int ch);
    logic [NCh*SW-1:0] v;
    v = sel;
    return int'(v[ch*SW +: SW]);
  endfunction

  function automatic int per(int s);
    return (2 * s + 1) * (1 << BS);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < NCh; c++) begin
      if (reset) begin
        m_pos[c] = 0; m_rate[c] = sel_of(c); m_sq[c] = 0; m_tk[c] = 0;
      end else if (restart[c]) begin
        m_pos[c] = 0; m_rate[c] = sel_of(c); m_sq[c] = 1; m_tk[c] = 0;
      end else if (en[c]) begin
        int p;
        p = per(m_rate[c]);
        if (m_pos[c] == p - 1) begin
          m_pos[c] = 0; m_tk[c] = 1; m_rate[c] = sel_of(c);
        end else begin
          m_pos[c] = m_pos[c] + 1; m_tk[c] = 0;
        end
        m_sq[c] = (m_pos[c] < p / 2);
      end else begin
        m_tk[c] = 0;
      end
    end
  endtask

  // One clock: model advances with the sampled inputs, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    for (int c = 0; c < NCh; c++) begin
      chk($sformatf("sq_out%0d", c), 32'(sq_out[c]), 32'(m_sq[c]));
      chk($sformatf("tick%0d", c), 32'(tick[c]), 32'(m_tk[c]));
    end
  endtask

  task automatic wait_tick0();
    bit ok;
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      step();
      ok = tick[0];
    end
    chk("wait_tick0", 32'(ok), 32'd1);
  endtask

  initial begin
    int ticks, highs, bad, first;
    logic prev_sq;
    reset = 1'b1; en = 2'b11; restart = 2'b00; sel = 4'b0000;
    #2;

    // 1: reset then P=4 on channel 0
    step(); step();
    chk("rst_sq", 32'(sq_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    reset = 1'b0;
    ticks = 0; highs = 0; bad = 0; prev_sq = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      ticks += int'(tick[0]);
      highs += int'(sq_out[0]);
      if (tick[0] && !(sq_out[0] && !prev_sq)) bad++;
      prev_sq = sq_out[0];
    end
    chk("t1_ticks", 32'(ticks), 32'd4);
    chk("t1_highs", 32'(highs), 32'd8);
    chk("t1_tick_on_rise", 32'(bad), 32'd0);

    // 2: rate change at cnt0=1 only applies after the wrap
    wait_tick0();
    step();
    sel[1:0] = 2'd1;
    step(); chk("t2_no_early0", 32'(tick[0]), 32'd0);
    step(); chk("t2_no_early1", 32'(tick[0]), 32'd0);
    step(); chk("t2_wrap4", 32'(tick[0]), 32'd1);
    ticks = 0; highs = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      ticks += int'(tick[0]);
      highs += int'(sq_out[0]);
    end
    chk("t2_highs12", 32'(highs), 32'd6);
    chk("t2_ticks12", 32'(ticks), 32'd1);
    chk("t2_tick_last", 32'(tick[0]), 32'd1);
    sel[1:0] = 2'd0;
    wait_tick0();

    // 3: en0 low for 5 cycles at start of high phase
    en[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_sq", 32'(sq_out[0]), 32'd1);
      chk("t3_hold_tick", 32'(tick[0]), 32'd0);
    end
    en[0] = 1'b1;
    step(); chk("t3_high2", 32'(sq_out[0]), 32'd1);
    step(); chk("t3_low", 32'(sq_out[0]), 32'd0);

    // 4: restart at cnt0=2 with sel0=3
    restart[0] = 1'b1; sel[1:0] = 2'd3;
    step();
    chk("t4_rs_sq", 32'(sq_out[0]), 32'd1);
    chk("t4_rs_tick", 32'(tick[0]), 32'd0);
    restart[0] = 1'b0;
    first = 0;
    for (int i = 1; i <= 40 && first == 0; i++) begin
      step();
      if (tick[0]) first = i;
    end
    chk("t4_first_tick", 32'(first), 32'd28);

    // 5: matched channels, then restart1 skews channel 1
    sel = 4'b0000; reset = 1'b1;
    step(); step();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tick[0] !== tick[1]) bad++;
    end
    chk("t5_sync", 32'(bad), 32'd0);
    restart[1] = 1'b1;
    step();
    restart[1] = 1'b0;
    bad = 0; ticks = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (tick[0] && tick[1]) bad++;
      ticks += int'(tick[0]);
    end
    chk("t5_skew", 32'(bad), 32'd0);
    chk("t5_ch0_ticks", 32'(ticks), 32'd4);

    // 6: mid-period reset with sel0=3
    step();
    sel[1:0] = 2'd3; reset = 1'b1;
    step();
    chk("t6_rst_sq", 32'(sq_out), 32'd0);
    chk("t6_rst_tick", 32'(tick), 32'd0);
    reset = 1'b0;
    first = 0;
    for (int i = 1; i <= 40 && first == 0; i++) begin
      step();
      if (tick[0]) first = i;
    end
    chk("t6_first_tick", 32'(first), 32'd28);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(0, 63) == 0);
      en      = NCh'($urandom);
      restart = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
      sel     = (NCh*SW)'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
